// File: rtl/vec_mac_acc.sv
// vec_mac_acc: four-stage pipelined signed fixed-point dot-product accumulator.
// Optional macro VEC_MAC_SAT_EN clamps out_y to the WIDTH-bit range and drives out_sat.
module vec_mac_acc #(
   parameter int WIDTH = 16,
   parameter int FRAC  = 10,
   parameter int LANES = 4,
   parameter int ACC_W = 2*WIDTH+8,
   parameter int CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic                   in_last,
   input  logic                   in_clear,
   input  logic [LANES*WIDTH-1:0] a,
   input  logic [LANES*WIDTH-1:0] b,
   output logic                   out_valid,
   output logic [WIDTH-1:0]       out_y,
   output logic [CNT_W-1:0]       out_count,
   output logic                   out_sat
);
   localparam int PW = 2*WIDTH;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic                    s1_valid, s1_last;
   logic [LANES*WIDTH-1:0]  s1_a, s1_b;
   logic                    s2_valid, s2_last;
   logic signed [PW-1:0]    s2_prod [LANES];
   logic signed [PW-1:0]    ext_a [LANES];
   logic signed [PW-1:0]    ext_b [LANES];
   logic signed [PW-1:0]    prod_c [LANES];
   logic                    s3_valid, s3_last;
   logic signed [ACC_W-1:0] s3_sum;
   logic signed [ACC_W-1:0] lane_sum;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_sum;
   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        cnt_inc;
   logic [WIDTH-1:0]        y_c;

   // Stage 1: operand capture; a clear in the same cycle discards the beat
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else if (in_clear) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_last <= in_last;
            s1_a    <= a;
            s1_b    <= b;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         ext_a[i]  = PW'($signed(s1_a[i*WIDTH +: WIDTH]));
         ext_b[i]  = PW'($signed(s1_b[i*WIDTH +: WIDTH]));
         prod_c[i] = ext_a[i] * ext_b[i];
      end
   end

   // Stage 2: full-precision lane products
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_last  <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            s2_prod[i] <= '0;
         end
      end else begin
         s2_valid <= s1_valid & ~in_clear;
         s2_last  <= s1_last;
         for (int i = 0; i < LANES; i++) begin
            s2_prod[i] <= prod_c[i];
         end
      end
   end

   // Each product is floored back to the input Q format before summing
   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_sum = lane_sum + ACC_W'(s2_prod[i] >>> FRAC);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s3_valid <= 1'b0;
         s3_last  <= 1'b0;
         s3_sum   <= '0;
      end else begin
         s3_valid <= s2_valid & ~in_clear;
         s3_last  <= s2_last;
         s3_sum   <= lane_sum;
      end
   end

   always_comb begin
      acc_sum = acc + s3_sum;
      cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
   end

`ifdef VEC_MAC_SAT_EN
   localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;
   logic sat_c;

   always_comb begin
      sat_c = 1'b0;
      y_c   = acc_sum[WIDTH-1:0];
      if (acc_sum > Y_MAX) begin
         sat_c = 1'b1;
         y_c   = {1'b0, {(WIDTH-1){1'b1}}};
      end else if (acc_sum < Y_MIN) begin
         sat_c = 1'b1;
         y_c   = {1'b1, {(WIDTH-1){1'b0}}};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_sat <= 1'b0;
      end else if (!in_clear && s3_valid && s3_last) begin
         out_sat <= sat_c;
      end
   end
`else
   assign y_c     = acc_sum[WIDTH-1:0];
   assign out_sat = 1'b0;
`endif

   // Stage 4: accumulate, or emit the finished vector and restart from zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_y     <= '0;
         out_count <= '0;
      end else begin
         out_valid <= 1'b0;
         if (in_clear) begin
            acc <= '0;
            cnt <= '0;
         end else if (s3_valid) begin
            if (s3_last) begin
               out_valid <= 1'b1;
               out_y     <= y_c;
               out_count <= cnt_inc;
               acc       <= '0;
               cnt       <= '0;
            end else begin
               acc <= acc_sum;
               cnt <= cnt_inc;
            end
         end
      end
   end

endmodule

// File: tb/tb_vec_mac_acc.sv
// Testbench for vec_mac_acc at default parameters: table of single-beat vectors,
// hand-written multi-cycle sequences, and a cycle-tagged scoreboard of expected results.
module tb_vec_mac_acc;
   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_last;
   logic        in_clear;
   logic [63:0] a;
   logic [63:0] b;
   logic        out_valid;
   logic [15:0] out_y;
   logic [7:0]  out_count;
   logic        out_sat;

   typedef struct {
      logic [15:0] y;
      logic [7:0]  cnt;
      logic        sat;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [15:0] y;
      logic        sat;
   } vec_t;

   localparam logic [63:0] D34A = 64'h0200_FC00_0800_0400;
   localparam logic [63:0] D34B = 64'h0400_0400_0400_0400;
   localparam logic [63:0] ONEA = 64'h0000_0000_0000_0001;

   exp_t        sb[$];
   exp_t        mon_e;
   vec_t        tab [8];
   int          checks = 0;
   int          passes = 0;
   int          cyc = 0;
   longint      m_sum = 0;
   int          m_cnt = 0;
   logic [15:0] last_y = '0;
   logic [7:0]  last_cnt = '0;

   vec_mac_acc dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_clear  (in_clear),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_y     (out_y),
      .out_count (out_count),
      .out_sat   (out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("[TB] FAIL %s: got %h required %h", name, got, exp);
   endtask

   function automatic longint lane_sum(logic [63:0] av, logic [63:0] bv);
      longint s = 0;
      for (int i = 0; i < 4; i++) begin
         s += (longint'($signed(av[i*16 +: 16])) * longint'($signed(bv[i*16 +: 16]))) >>> 10;
      end
      return s;
   endfunction

   // Reference output formatting: clamp when saturation is built in, else keep low bits
   task automatic model_out(input longint s, output logic [15:0] y, output logic sat);
      y   = s[15:0];
      sat = 1'b0;
`ifdef VEC_MAC_SAT_EN
      if (s > 32767) begin
         y = 16'h7FFF; sat = 1'b1;
      end else if (s < -32768) begin
         y = 16'h8000; sat = 1'b1;
      end
`endif
   endtask

   // Drive one cycle of input; expectations are queued with the cycle they must appear on
   task automatic applyStimulus(bit v, bit l, bit c, logic [63:0] av, logic [63:0] bv,
                                bit use_tab, logic [15:0] ty, logic ts);
      exp_t e;
      in_valid = v;
      in_last  = l;
      in_clear = c;
      a        = av;
      b        = bv;
      if (c) begin
         m_sum = 0;
         m_cnt = 0;
         while (sb.size() > 0 && sb[$].cyc >= cyc + 1) void'(sb.pop_back());
      end else if (v) begin
         m_sum += lane_sum(av, bv);
         if (m_cnt < 255) m_cnt++;
         if (l) begin
            if (use_tab) begin
               e.y = ty; e.sat = ts;
            end else begin
               model_out(m_sum, e.y, e.sat);
            end
            e.cnt = 8'(m_cnt);
            e.cyc = cyc + 4;
            sb.push_back(e);
            m_sum = 0;
            m_cnt = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic beat(bit v, bit l, bit c, logic [63:0] av, logic [63:0] bv);
      applyStimulus(v, l, c, av, bv, 1'b0, 16'h0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && sb.size() > 0; i++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("drain", sb.size(), 0);
   endtask

   // Output monitor sampled on the falling edge
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (sb.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpected_out: got out_valid=1 at cycle %0d required 0", cyc);
         end else begin
            mon_e = sb.pop_front();
            checkOutput("out_y", 32'(out_y), 32'(mon_e.y));
            checkOutput("out_count", 32'(out_count), 32'(mon_e.cnt));
            checkOutput("out_sat", 32'(out_sat), 32'(mon_e.sat));
            checkOutput("out_cycle", cyc, mon_e.cyc);
            last_y   = mon_e.y;
            last_cnt = mon_e.cnt;
         end
      end else if (!rst && sb.size() > 0 && sb[0].cyc <= cyc) begin
         checks++;
         $display("[TB] FAIL missing_out: got out_valid=0 at cycle %0d required 1", cyc);
         void'(sb.pop_front());
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      tab[0] = '{D34A, D34B, 16'h0A00, 1'b0};
      tab[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0001_0001_0001_0001, 16'hFFFC, 1'b0};
`ifdef VEC_MAC_SAT_EN
      tab[2] = '{64'h7C00_7C00_7C00_7C00, 64'h7C00_7C00_7C00_7C00, 16'h7FFF, 1'b1};
      tab[5] = '{64'h0000_0000_0000_8000, 64'h0000_0000_0000_8000, 16'h7FFF, 1'b1};
      tab[6] = '{64'h8000_8000_8000_8000, 64'h7FFF_7FFF_7FFF_7FFF, 16'h8000, 1'b1};
`else
      tab[2] = '{64'h7C00_7C00_7C00_7C00, 64'h7C00_7C00_7C00_7C00, 16'h1000, 1'b0};
      tab[5] = '{64'h0000_0000_0000_8000, 64'h0000_0000_0000_8000, 16'h0000, 1'b0};
      tab[6] = '{64'h8000_8000_8000_8000, 64'h7FFF_7FFF_7FFF_7FFF, 16'h0080, 1'b0};
`endif
      tab[3] = '{64'h0, D34B, 16'h0000, 1'b0};
      tab[4] = '{64'h0000_0000_0000_8000, 64'h0000_0000_0000_0400, 16'h8000, 1'b0};
      tab[7] = '{64'h0000_0000_0003_0001, 64'h0000_0000_FFFF_0001, 16'hFFFF, 1'b0};

      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_clear = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_valid", 32'(out_valid), 0);
      checkOutput("reset_y", 32'(out_y), 0);
      checkOutput("reset_count", 32'(out_count), 0);
      checkOutput("reset_sat", 32'(out_sat), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] table of single-beat vectors, back to back");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, tab[i].a, tab[i].b, 1'b1, tab[i].y, tab[i].sat);
      end
      beat(1'b0, 1'b0, 1'b0, '0, '0);
      drain();

      $display("[TB] two-beat vector then one-beat vector, no gap");
      beat(1'b1, 1'b0, 1'b0, D34A, D34B);
      beat(1'b1, 1'b1, 1'b0, D34A, D34B);
      beat(1'b1, 1'b1, 1'b0, D34A, D34B);
      beat(1'b0, 1'b0, 1'b0, '0, '0);
      drain();

      $display("[TB] idle cycles inside a vector");
      beat(1'b1, 1'b0, 1'b0, D34A, D34B);
      beat(1'b0, 1'b1, 1'b0, D34A, D34B);
      beat(1'b0, 1'b0, 1'b0, '0, '0);
      beat(1'b1, 1'b1, 1'b0, tab[7].a, tab[7].b);
      beat(1'b0, 1'b0, 1'b0, '0, '0);
      drain();

      $display("[TB] abort with clear on the fourth beat");
      for (int i = 0; i < 3; i++) beat(1'b1, 1'b0, 1'b0, D34A, D34B);
      beat(1'b1, 1'b1, 1'b1, D34A, D34B);
      beat(1'b1, 1'b1, 1'b0, D34A, D34B);
      beat(1'b0, 1'b0, 1'b0, '0, '0);
      drain();

      $display("[TB] clear drops an in-flight last beat");
      beat(1'b1, 1'b1, 1'b0, tab[2].a, tab[2].b);
      beat(1'b0, 1'b0, 1'b0, '0, '0);
      beat(1'b0, 1'b0, 1'b1, '0, '0);
      beat(1'b1, 1'b1, 1'b0, tab[1].a, tab[1].b);
      beat(1'b0, 1'b0, 1'b0, '0, '0);
      drain();

      $display("[TB] beat counter saturation");
      for (int i = 0; i < 259; i++) beat(1'b1, 1'b0, 1'b0, ONEA, D34B);
      beat(1'b1, 1'b1, 1'b0, ONEA, D34B);
      beat(1'b0, 1'b0, 1'b0, '0, '0);
      drain();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("hold_y", 32'(out_y), 32'(last_y));
      checkOutput("hold_count", 32'(out_count), 32'(last_cnt));

      $display("[TB] reset between beats of a vector");
      beat(1'b1, 1'b0, 1'b0, D34A, D34B);
      in_valid = 1'b0;
      rst = 1'b1;
      sb.delete();
      m_sum = 0;
      m_cnt = 0;
      #1;
      checkOutput("midreset_valid", 32'(out_valid), 0);
      checkOutput("midreset_y", 32'(out_y), 0);
      checkOutput("midreset_count", 32'(out_count), 0);
      checkOutput("midreset_sat", 32'(out_sat), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      beat(1'b1, 1'b1, 1'b0, D34A, D34B);
      beat(1'b0, 1'b0, 1'b0, '0, '0);
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/vec_mac_acc.md
VEC_MAC_ACC -- requirements
Module: vec_mac_acc

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in signed fixed point (1 sign + int + FRAC bits).
REQ-002 Parameter FRAC, default 10, fraction bits (Q5.10 at defaults); FRAC < WIDTH.
REQ-003 Parameter LANES, default 4, parallel multiplier lanes per beat; power of two, 1..16.
REQ-004 Parameter ACC_W, default 2*WIDTH+8, internal accumulator width.
REQ-005 Parameter CNT_W, default 8, beat-counter width.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 in_valid  input  1  beat present on a/b this cycle.
REQ-009 in_last  input  1  qualifies final beat of a vector; ignored when in_valid=0.
REQ-010 in_clear  input  1  synchronous abort of the current vector.
REQ-011 a  input  LANES*WIDTH  packed signed operands, lane i at bits [i*WIDTH +: WIDTH].
REQ-012 b  input  LANES*WIDTH  packed signed operands, same packing.
REQ-013 out_valid  output  1  one-cycle pulse, out_y/out_count/out_sat valid.
REQ-014 out_y  output  WIDTH  signed dot-product result, same Q format as inputs.
REQ-015 out_count  output  CNT_W  number of beats in the completed vector.
REQ-016 out_sat  output  1  result was clamped (0 when macro absent).

Function
REQ-017 Stage 1 (edge k) SHALL register a, b, in_last and valid when in_valid=1; stage valid clears when in_valid=0.
REQ-018 Stage 2 (edge k+1) SHALL form per-lane full-precision 2*WIDTH-bit signed products.
REQ-019 Stage 3 (edge k+2) SHALL sum over lanes of (product >>> FRAC), arithmetic shift (floor), sign-extended to ACC_W; no overflow in the tree.
REQ-020 Stage 4 (edge k+3) SHALL update acc <= acc + lane_sum, wrapping modulo 2^ACC_W.
REQ-021 For a last beat, stage 4 SHALL register out_y from acc + lane_sum, assert out_valid for one cycle, and load acc with 0.
REQ-022 Latency: out_valid asserts after edge k+3, where k is the edge capturing the last beat.
REQ-023 Beats MAY arrive every cycle; a beat following a last beat SHALL start a new vector from zero with no bubble.
REQ-024 Idle cycles (in_valid=0) within a vector SHALL leave acc and the counter unchanged.
REQ-025 Beat counter SHALL increment per accepted beat at stage 4, saturate at 2^CNT_W-1, present total on out_count, reset to 0 after last.
REQ-026 Without saturation, out_y SHALL be the low WIDTH bits of the final sum.
REQ-027 in_clear=1 SHALL, at that edge, zero acc and counter and drop all in-flight stage valids; no out_valid results from dropped beats.
REQ-028 in_clear and in_valid in the same cycle: clear wins, that beat is discarded.
REQ-029 out_y, out_count, out_sat SHALL hold their last values while out_valid=0.

Reset
REQ-030 rst=1 SHALL asynchronously clear all stage valids, acc, counter, out_valid, out_y, out_count, out_sat to 0.
REQ-031 Reset mid-vector SHALL discard the partial vector; the first beat after release starts a new vector.

Configuration
REQ-032 Macro VEC_MAC_SAT_EN defined: out_y SHALL clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and out_sat=1 when clamped.
REQ-033 Macro VEC_MAC_SAT_EN undefined: no clamp logic, wrap per REQ-026, out_sat tied 0.

Verification (defaults WIDTH=16 FRAC=10 LANES=4)
REQ-034 Single beat last, a={1.0,2.0,-1.0,0.5}={0x0400,0x0800,0xFC00,0x0200}, b all 0x0400 -> out_y=0x0A00, out_count=1, out_valid 3 cycles after capture.
REQ-035 Two back-to-back vectors (2 beats of REQ-034 data, then 1 beat) with no gaps -> out_y=0x1400 count=2, then 0x0A00 count=1, consecutive pulses 1 cycle apart.
REQ-036 Floor rounding: all lanes a=0xFFFF, b=0x0001, last -> out_y=0xFFFC.
REQ-037 All lanes a=b=0x7C00, last -> with VEC_MAC_SAT_EN out_y=0x7FFF out_sat=1; without out_y=0x1000 out_sat=0.
REQ-038 Abort: 3 beats, in_clear with 4th beat, then 1 REQ-034 beat last -> single out_valid, out_y=0x0A00, count=1.
REQ-039 rst pulsed between beats 1 and 2 of a vector -> all outputs 0 immediately; subsequent 1-beat vector yields out_y=0x0A00 count=1.
